// File: rtl/relay_pkg.sv
// Shared types and constants for the relay debounce and drive blocks.
package relay_pkg;

    typedef enum logic [2:0] {
        OFF_IDLE = 3'd0,
        ON_MIN   = 3'd1,
        ON_HOLD  = 3'd2,
        OFF_MIN  = 3'd3,
        FAULT    = 3'd4
    } relay_state_e;

    localparam logic low_p        = 1'b0;
    localparam logic high_p       = 1'b1;
    localparam int   single_bit_p = 1;

endpackage

// File: rtl/relay_dwell_timer.sv
// Saturating up-counter with synchronous clear.
// Done_o flags the cycle in which the count reaches Last_i.
module relay_dwell_timer #(
    parameter int unsigned CNT_W_P = 32
) (
    input  logic               Clk_i,
    input  logic               Reset_i,
    input  logic               Clear_i,
    input  logic [CNT_W_P-1:0] Last_i,
    output logic               Done_o
);

    logic [CNT_W_P-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W_P'(1);
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Done_o = (cnt_q >= Last_i);

endmodule

// File: rtl/relay_drive_ctrl.sv
// Relay coil drive: min on/off dwell, global enable and max-on fault.
// Sits directly downstream of the relay debounce block.
module relay_drive_ctrl
    import relay_pkg::*;
#(
    parameter int unsigned CNT_W_P   = 32,
    parameter int unsigned MIN_ON_P  = 5_000_000,
    parameter int unsigned MIN_OFF_P = 5_000_000,
    parameter int unsigned MAX_ON_P  = 500_000_000
) (
    input  logic Clk_i,
    input  logic Reset_i,
    input  logic Request_i,
    input  logic Enable_i,
    output logic Relay_o,
    output logic Busy_o,
    output logic Fault_o
);

    localparam logic [CNT_W_P-1:0] ON_LAST_C  = CNT_W_P'(MIN_ON_P - 1);
    localparam logic [CNT_W_P-1:0] OFF_LAST_C = CNT_W_P'(MIN_OFF_P - 1);

    relay_state_e state_q, state_d;

    logic               on_q;
    logic               dwell_clr;
    logic               dwell_done;
    logic               max_done;
    logic [CNT_W_P-1:0] dwell_last;
    logic               relay_q, busy_q, fault_q;

    assign on_q       = (state_q == ON_MIN) || (state_q == ON_HOLD);
    assign dwell_clr  = (state_d != state_q);
    assign dwell_last = (state_q == ON_MIN) ? ON_LAST_C : OFF_LAST_C;

    relay_dwell_timer #(
        .CNT_W_P (CNT_W_P)
    ) u_dwell (
        .Clk_i   (Clk_i),
        .Reset_i (Reset_i),
        .Clear_i (dwell_clr),
        .Last_i  (dwell_last),
        .Done_o  (dwell_done)
    );

    // On-time counter only runs while the coil is driven.
    if (MAX_ON_P != 0) begin : g_max_on
        localparam logic [CNT_W_P-1:0] MAX_LAST_C = CNT_W_P'(MAX_ON_P - 1);

        relay_dwell_timer #(
            .CNT_W_P (CNT_W_P)
        ) u_max_on (
            .Clk_i   (Clk_i),
            .Reset_i (Reset_i),
            .Clear_i (!on_q),
            .Last_i  (MAX_LAST_C),
            .Done_o  (max_done)
        );
    end else begin : g_no_max_on
        assign max_done = low_p;
    end

    // Priority: enable drop, then timeout, then request change.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OFF_IDLE: begin
                if (Request_i && Enable_i) state_d = ON_MIN;
            end
            ON_MIN: begin
                if (!Enable_i)       state_d = OFF_MIN;
                else if (max_done)   state_d = FAULT;
                else if (dwell_done) state_d = ON_HOLD;
            end
            ON_HOLD: begin
                if (!Enable_i)      state_d = OFF_MIN;
                else if (max_done)  state_d = FAULT;
                else if (!Request_i) state_d = OFF_MIN;
            end
            OFF_MIN: begin
                if (dwell_done) state_d = OFF_IDLE;
            end
            FAULT: begin
                if (!Request_i) state_d = OFF_MIN;
            end
            default: state_d = OFF_IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state_q <= OFF_IDLE;
            relay_q <= low_p;
            busy_q  <= low_p;
            fault_q <= low_p;
        end else begin
            state_q <= state_d;
            relay_q <= (state_d == ON_MIN) || (state_d == ON_HOLD);
            busy_q  <= (state_d == ON_MIN) || (state_d == OFF_MIN);
            fault_q <= (state_d == FAULT);
        end
    end

    assign Relay_o = relay_q;
    assign Busy_o  = busy_q;
    assign Fault_o = fault_q;

endmodule

// File: tb/tb_relay_drive_ctrl.sv
// Directed bench for relay_drive_ctrl with MIN_ON=4, MIN_OFF=3, MAX_ON=10.
module tb_relay_drive_ctrl;

    logic clk;
    logic rst_n;
    logic req;
    logic en;
    logic relay;
    logic busy;
    logic fault;

    int checks = 0;
    int errors = 0;

    relay_drive_ctrl #(
        .CNT_W_P   (32),
        .MIN_ON_P  (4),
        .MIN_OFF_P (3),
        .MAX_ON_P  (10)
    ) dut (
        .Clk_i     (clk),
        .Reset_i   (rst_n),
        .Request_i (req),
        .Enable_i  (en),
        .Relay_o   (relay),
        .Busy_o    (busy),
        .Fault_o   (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic r, input logic b,
                        input logic f);
        chk({tag, "_relay"}, relay, r);
        chk({tag, "_busy"}, busy, b);
        chk({tag, "_fault"}, fault, f);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        en    = 1'b0;
        #23;
        chk3("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        step();
        chk3("idle", 1'b0, 1'b0, 1'b0);

        // 1: request held -> on at cycle 1, fault at cycle 11
        req = 1'b1;
        en  = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk3($sformatf("t1_c%0d", k), k <= 10, k <= 4, k == 11);
        end

        // 6: fault holds while request high, exits on release
        step();
        step();
        chk3("t6_hold", 1'b0, 1'b0, 1'b1);
        req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk3($sformatf("t6_c%0d", k), 1'b0, k <= 3, 1'b0);
        end

        // 2: single-cycle request
        req = 1'b1;
        step();
        chk3("t2_c1", 1'b1, 1'b1, 1'b0);
        req = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            step();
            chk3($sformatf("t2_c%0d", k), k <= 5,
                 (k <= 4) || (k >= 6 && k <= 8), 1'b0);
        end

        // 3: re-request one cycle after release
        req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk3($sformatf("t3_on%0d", k), 1'b1, k <= 4, 1'b0);
        end
        req = 1'b0;
        step();
        chk3("t3_c6", 1'b0, 1'b1, 1'b0);
        req = 1'b1;
        for (int k = 7; k <= 10; k++) begin
            step();
            chk3($sformatf("t3_c%0d", k), k == 10, (k <= 8) || (k == 10),
                 1'b0);
        end

        // 4: enable drop two cycles into ON_MIN
        step();
        chk3("t4_c2", 1'b1, 1'b1, 1'b0);
        en = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            step();
            chk3($sformatf("t4_c%0d", k), 1'b0, k <= 5, 1'b0);
        end
        en = 1'b1;
        step();
        chk3("t4_rearm", 1'b1, 1'b1, 1'b0);

        // 5: async reset mid ON_HOLD
        for (int k = 2; k <= 6; k++) step();
        chk3("t5_hold", 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk3("t5_rst", 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        req   = 1'b0;
        step();
        chk3("t5_idle", 1'b0, 1'b0, 1'b0);

        // enable drop beats max-on timeout on the same edge
        req = 1'b1;
        for (int k = 1; k <= 10; k++) step();
        chk3("pri_c10", 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        step();
        chk3("pri_c11", 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
